// File: rtl/branch_redirect_ctrl_if.sv
// rtl/branch_redirect_ctrl_if.sv - branch resolve/retire/redirect bundle
//
// Groups the branch-unit resolve port, the ROB-head retire port and the
// flush/redirect/stall outputs of branch_redirect_ctrl.
//   master : branch unit + ROB side (drives resolve_* and retire_*)
//   slave  : branch_redirect_ctrl (drives ready, flush, redirect, stall, counts)
interface branch_redirect_ctrl_if #(
    parameter int XLEN     = 32,
    parameter int ROB_SIZE = 8
);
    localparam int IDXW = $clog2(ROB_SIZE);

    logic            resolve_valid;
    logic [IDXW-1:0] resolve_rob_idx;
    logic            resolve_cond;
    logic [XLEN-1:0] resolve_target;

    logic            retire_valid;
    logic            retire_is_branch;
    logic [IDXW-1:0] retire_rob_idx;

    logic            branch_ready;
    logic            flush;
    logic [XLEN-1:0] redirect_pc;
    logic            fetch_stall;
    logic [15:0]     branch_count;
    logic [15:0]     mispredict_count;

    modport master (
        output resolve_valid, resolve_rob_idx, resolve_cond, resolve_target,
        output retire_valid, retire_is_branch, retire_rob_idx,
        input  branch_ready, flush, redirect_pc, fetch_stall,
        input  branch_count, mispredict_count
    );

    modport slave (
        input  resolve_valid, resolve_rob_idx, resolve_cond, resolve_target,
        input  retire_valid, retire_is_branch, retire_rob_idx,
        output branch_ready, flush, redirect_pc, fetch_stall,
        output branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - per-ROB branch outcome table with flush/redirect on retire
//
// Holds resolved branch outcomes per ROB tag until the branch reaches ROB
// head. The front end predicts not-taken, so any taken outcome retiring is a
// mispredict: issue a one-cycle flush with the stored target, then hold fetch
// for RECOVER_CYCLES more cycles.
// Ports:
//   clock, reset : single clock, asynchronous active-high reset
//   bus (slave)  : resolve_* in, retire_* in, branch_ready (comb),
//                  flush / redirect_pc / fetch_stall (registered),
//                  branch_count / mispredict_count (16-bit, wrapping)
module branch_redirect_ctrl #(
    parameter int XLEN           = 32,
    parameter int ROB_SIZE       = 8,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    branch_redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t state, state_next;
    logic [3:0] rec_cnt, rec_cnt_next;

    logic [ROB_SIZE-1:0] ent_valid;
    logic [ROB_SIZE-1:0] ent_cond;
    logic [XLEN-1:0]     ent_target [ROB_SIZE];

    logic            flush_q;
    logic            stall_q;
    logic [XLEN-1:0] redirect_q;
    logic [15:0]     branch_cnt_q;
    logic [15:0]     mispredict_cnt_q;

    logic            is_idle;
    logic            bypass_hit;
    logic            head_valid;
    logic            head_cond;
    logic [XLEN-1:0] head_target;
    logic            ready;
    logic            mispredict;
    logic            resolve_wr;

    assign is_idle = (state == ST_IDLE);

    // Same-cycle resolve of the head tag wins over whatever the table holds.
    assign bypass_hit  = bus.resolve_valid && (bus.resolve_rob_idx == bus.retire_rob_idx);
    assign head_valid  = ent_valid[bus.retire_rob_idx] | bypass_hit;
    assign head_cond   = bypass_hit ? bus.resolve_cond   : ent_cond[bus.retire_rob_idx];
    assign head_target = bus.resolve_valid && bypass_hit ? bus.resolve_target
                                                          : ent_target[bus.retire_rob_idx];

    // Gated by reset so a bypassed retire cannot look ready while in reset.
    assign ready = bus.retire_valid && bus.retire_is_branch && head_valid
                   && is_idle && !reset;
    assign mispredict = ready && head_cond;

    // Resolves outside IDLE belong to squashed instructions.
    assign resolve_wr = bus.resolve_valid && is_idle;

    always_comb begin
        state_next   = state;
        rec_cnt_next = rec_cnt;
        case (state)
            ST_IDLE: begin
                if (mispredict) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                rec_cnt_next = 4'(RECOVER_CYCLES);
                state_next   = ST_RECOVER;
            end
            ST_RECOVER: begin
                rec_cnt_next = rec_cnt - 4'd1;
                // Counter hits zero this cycle: next cycle is IDLE.
                if (rec_cnt <= 4'd1) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                rec_cnt_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            rec_cnt          <= 4'd0;
            flush_q          <= 1'b0;
            stall_q          <= 1'b0;
            redirect_q       <= '0;
            branch_cnt_q     <= 16'd0;
            mispredict_cnt_q <= 16'd0;
        end else begin
            state   <= state_next;
            rec_cnt <= rec_cnt_next;
            // Outputs are decoded from the next state so they line up with
            // the state they describe, without a combinational path out.
            flush_q <= (state_next == ST_FLUSH);
            stall_q <= (state_next != ST_IDLE);
            if (ready) begin
                branch_cnt_q <= branch_cnt_q + 16'd1;
            end
            if (mispredict) begin
                mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
                redirect_q       <= head_target;
            end
        end
    end

    // Valid bits: retire clear is applied after the resolve write so a
    // bypassed same-index pair leaves the entry empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent_valid <= '0;
        end else if (state == ST_FLUSH) begin
            ent_valid <= '0;
        end else begin
            if (resolve_wr) begin
                ent_valid[bus.resolve_rob_idx] <= 1'b1;
            end
            if (ready) begin
                ent_valid[bus.retire_rob_idx] <= 1'b0;
            end
        end
    end

    // Payload needs no reset; it is only read while its valid bit is set.
    always_ff @(posedge clock) begin
        if (resolve_wr) begin
            ent_cond[bus.resolve_rob_idx]   <= bus.resolve_cond;
            ent_target[bus.resolve_rob_idx] <= bus.resolve_target;
        end
    end

    assign bus.branch_ready     = ready;
    assign bus.flush            = flush_q;
    assign bus.redirect_pc      = redirect_q;
    assign bus.fetch_stall      = stall_q;
    assign bus.branch_count     = branch_cnt_q;
    assign bus.mispredict_count = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - scoreboard bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;
    localparam int XLEN           = 32;
    localparam int ROB_SIZE       = 8;
    localparam int RECOVER_CYCLES = 2;
    localparam int IDXW           = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    branch_redirect_ctrl_if #(.XLEN(XLEN), .ROB_SIZE(ROB_SIZE)) bus ();

    branch_redirect_ctrl #(
        .XLEN(XLEN), .ROB_SIZE(ROB_SIZE), .RECOVER_CYCLES(RECOVER_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];
    logic [31:0] sb_exp;
    logic [15:0] exp_bc = 16'd0;
    logic [15:0] exp_mc = 16'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic rv, input logic [IDXW-1:0] ridx, input logic rcond,
                          input logic [XLEN-1:0] rtgt, input logic tv, input logic tbr,
                          input logic [IDXW-1:0] tidx);
        bus.resolve_valid    = rv;
        bus.resolve_rob_idx  = ridx;
        bus.resolve_cond     = rcond;
        bus.resolve_target   = rtgt;
        bus.retire_valid     = tv;
        bus.retire_is_branch = tbr;
        bus.retire_rob_idx   = tidx;
    endtask

    task automatic idle_in();
        set_in(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.fetch_stall && n < 20) begin
            step();
            n++;
        end
        if (bus.fetch_stall) check_eq("idle_timeout", 32'(bus.fetch_stall), 32'd0);
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_branch_count"}, 32'(bus.branch_count), 32'(exp_bc));
        check_eq({tag, "_mispredict_count"}, 32'(bus.mispredict_count), 32'(exp_mc));
    endtask

    // Every flush pulse must match the oldest outstanding expected redirect.
    always @(negedge clock) begin
        if (!reset && bus.flush) begin
            if (sb_q.size() == 0) begin
                check_eq("flush_unexpected", 32'(sb_q.size()), 32'd1);
            end else begin
                sb_exp = sb_q.pop_front();
                check_eq("redirect_pc", bus.redirect_pc, sb_exp);
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_in();
        step();
        step();
        // Reset state, with a bypassed retire offered during reset.
        set_in(1'b1, 3'd2, 1'b1, 32'h55, 1'b1, 1'b1, 3'd2);
        #1;
        check_eq("rst_branch_ready", 32'(bus.branch_ready), 32'd0);
        check_eq("rst_flush", 32'(bus.flush), 32'd0);
        check_eq("rst_fetch_stall", 32'(bus.fetch_stall), 32'd0);
        check_eq("rst_redirect_pc", bus.redirect_pc, 32'd0);
        check_counts("rst");
        idle_in();
        step();
        reset = 1'b0;
        step();

        // Not-taken resolve then retire next cycle.
        set_in(1'b1, 3'd3, 1'b0, 32'h300, 1'b0, 1'b0, '0);
        step();
        set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 3'd3);
        #1;
        check_eq("nt_ready", 32'(bus.branch_ready), 32'd1);
        exp_bc++;
        step();
        check_eq("nt_flush", 32'(bus.flush), 32'd0);
        check_eq("nt_stall", 32'(bus.fetch_stall), 32'd0);
        #1;
        check_eq("nt_again_ready", 32'(bus.branch_ready), 32'd0);
        step();
        check_counts("nt");
        // Non-branch retire is ignored.
        set_in(1'b1, 3'd4, 1'b0, '0, 1'b1, 1'b0, 3'd4);
        #1;
        check_eq("nonbranch_ready", 32'(bus.branch_ready), 32'd0);
        step();
        idle_in();
        check_counts("nonbranch");

        // Mispredict with stall window and dropped resolve during recovery.
        set_in(1'b1, 3'd5, 1'b1, 32'h0000_1040, 1'b0, 1'b0, '0);
        step();
        set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 3'd5);
        #1;
        check_eq("mp_ready", 32'(bus.branch_ready), 32'd1);
        sb_q.push_back(32'h0000_1040);
        exp_bc++;
        exp_mc++;
        step();
        for (int k = 1; k <= RECOVER_CYCLES + 1; k++) begin
            if (k == 2) set_in(1'b1, 3'd4, 1'b1, 32'hdead, 1'b1, 1'b1, 3'd4);
            else idle_in();
            #1;
            check_eq("mp_stall", 32'(bus.fetch_stall), 32'd1);
            check_eq("mp_flush", 32'(bus.flush), (k == 1) ? 32'd1 : 32'd0);
            check_eq("mp_ready_forced", 32'(bus.branch_ready), 32'd0);
            step();
        end
        idle_in();
        check_eq("mp_stall_end", 32'(bus.fetch_stall), 32'd0);
        check_counts("mp");
        set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 3'd4);
        #1;
        check_eq("mp_dropped_ready", 32'(bus.branch_ready), 32'd0);
        step();
        idle_in();

        // Bypass: resolve and retire same index same cycle.
        set_in(1'b1, 3'd2, 1'b1, 32'h200, 1'b1, 1'b1, 3'd2);
        #1;
        check_eq("byp_ready", 32'(bus.branch_ready), 32'd1);
        sb_q.push_back(32'h200);
        exp_bc++;
        exp_mc++;
        step();
        idle_in();
        check_eq("byp_flush", 32'(bus.flush), 32'd1);
        wait_idle();
        set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 3'd2);
        #1;
        check_eq("byp_cleared_ready", 32'(bus.branch_ready), 32'd0);
        step();
        check_counts("byp");

        // Flush squash of preloaded entries and recovery-time resolves.
        set_in(1'b1, 3'd0, 1'b1, 32'h3000, 1'b0, 1'b0, '0);
        step();
        set_in(1'b1, 3'd1, 1'b0, 32'h10, 1'b0, 1'b0, '0);
        step();
        set_in(1'b1, 3'd6, 1'b1, 32'h60, 1'b0, 1'b0, '0);
        step();
        set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 3'd0);
        #1;
        check_eq("sq_ready", 32'(bus.branch_ready), 32'd1);
        sb_q.push_back(32'h3000);
        exp_bc++;
        exp_mc++;
        step();
        idle_in();
        step();
        set_in(1'b1, 3'd7, 1'b1, 32'h70, 1'b0, 1'b0, '0);
        step();
        idle_in();
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            logic [IDXW-1:0] idx;
            idx = (i == 0) ? 3'd1 : (i == 1) ? 3'd6 : 3'd7;
            set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, idx);
            #1;
            check_eq($sformatf("sq_ready_idx%0d", idx), 32'(bus.branch_ready), 32'd0);
            step();
        end
        idle_in();
        check_counts("sq");

        // Asynchronous reset mid-RECOVER.
        set_in(1'b1, 3'd3, 1'b1, 32'h4440, 1'b0, 1'b0, '0);
        step();
        set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 3'd3);
        #1;
        check_eq("ar_ready", 32'(bus.branch_ready), 32'd1);
        sb_q.push_back(32'h4440);
        step();
        idle_in();
        step();
        check_eq("ar_in_recover", 32'(bus.fetch_stall), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        exp_bc = 16'd0;
        exp_mc = 16'd0;
        check_eq("ar_flush", 32'(bus.flush), 32'd0);
        check_eq("ar_stall", 32'(bus.fetch_stall), 32'd0);
        check_eq("ar_redirect", bus.redirect_pc, 32'd0);
        check_counts("ar");
        set_in(1'b1, 3'd1, 1'b0, '0, 1'b1, 1'b1, 3'd1);
        #1;
        check_eq("ar_ready_in_reset", 32'(bus.branch_ready), 32'd0);
        step();
        idle_in();
        reset = 1'b0;
        step();
        check_eq("ar_no_residual_flush", 32'(bus.flush), 32'd0);
        check_eq("ar_no_residual_stall", 32'(bus.fetch_stall), 32'd0);

        // Counter wrap with back-to-back bypassed not-taken retires.
        for (int i = 0; i < 65535; i++) begin
            set_in(1'b1, IDXW'(i), 1'b0, 32'(i), 1'b1, 1'b1, IDXW'(i));
            step();
        end
        check_eq("wrap_ffff", 32'(bus.branch_count), 32'h0000_ffff);
        check_eq("wrap_stall", 32'(bus.fetch_stall), 32'd0);
        set_in(1'b1, 3'd0, 1'b0, '0, 1'b1, 1'b1, 3'd0);
        step();
        idle_in();
        check_counts("wrap");

        step();
        check_eq("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Receives resolved branch outcomes from the branch unit and holds them per ROB entry until the branch retires. The pipeline predicts not-taken, so any resolved `cond=1` (taken branch or jump) is a misprediction. When such a branch reaches ROB head, this block issues a one-cycle pipeline flush, redirects fetch to the stored target, and holds fetch through a fixed recovery window. It sits between the execute-stage branch unit and the ROB-retire / fetch logic.

## Interface
- `XLEN`, 32: data/PC width.
- `ROB_SIZE`, 8: ROB entries; power of two, ≥2. `IDXW = $clog2(ROB_SIZE)`.
- `RECOVER_CYCLES`, 2: fetch-hold cycles after flush; range 1..15.
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `resolve_valid` in 1: branch-unit result valid this cycle.
- `resolve_rob_idx` in IDXW: ROB tag of the resolving branch.
- `resolve_cond` in 1: 1 = taken, which means mispredict.
- `resolve_target` in XLEN: target PC from the branch unit.
- `retire_valid` in 1: ROB head wants to retire this cycle.
- `retire_is_branch` in 1: ROB head is a branch/jump.
- `retire_rob_idx` in IDXW: ROB head tag.
- `branch_ready` out 1: combinational; head branch result is available, either stored or bypassed.
- `flush` out 1: registered one-cycle flush pulse.
- `redirect_pc` out XLEN: registered; valid while `flush`=1.
- `fetch_stall` out 1: registered; high during FLUSH and RECOVER.
- `branch_count` out 16: retired branches, wraps.
- `mispredict_count` out 16: flushes issued, wraps.

## Operation
- Table of ROB_SIZE entries, each holding {valid, cond, target}, indexed by ROB tag.
- Resolve write: if `resolve_valid` and state==IDLE, then entry[resolve_rob_idx] ← {1, resolve_cond, resolve_target}. This overwrites any existing entry.
- `branch_ready` = retire_valid & retire_is_branch & (entry[retire_rob_idx].valid | (resolve_valid & resolve_rob_idx==retire_rob_idx)) & state==IDLE.
- Bypass: on same-cycle resolve and retire of the same index, the resolve data is used for retirement, and the entry is not left valid.
- Retire event, which occurs when `branch_ready`:
  - Clear entry valid.
  - Increment `branch_count`.
  - If cond=1: increment `mispredict_count`, latch target into `redirect_pc`, and go to FLUSH.
- Retire request with `branch_ready`=0 has no effect. The ROB must hold the head.
- FSM:
  - IDLE: waits for a retire event with cond=1, then goes to FLUSH.
  - FLUSH: lasts one cycle with `flush`=1; clears all table valid bits; loads the counter with RECOVER_CYCLES; goes to RECOVER.
  - RECOVER: the counter decrements each cycle; on the cycle the counter reaches 0, goes to IDLE.
- Resolves arriving in FLUSH or RECOVER are dropped. Those instructions are squashed.
- Non-branch retires are ignored.

## Timing
- Reset, asynchronous: all table valid=0; state=IDLE; `flush`=0; `fetch_stall`=0; `redirect_pc`=0; both counts=0; recovery counter=0.
- Reset asserted mid-FLUSH or mid-RECOVER returns the block immediately to the reset state, with no residual pulse.
- Resolve at edge t is visible to `branch_ready` from cycle t+1; in cycle t it is visible via bypass.
- Mispredicting retire in cycle t:
  - `flush`=1 and `redirect_pc`=target in cycle t+1.
  - `fetch_stall`=1 for cycles t+1 .. t+1+RECOVER_CYCLES, which is 1+RECOVER_CYCLES cycles.
  - `branch_ready` is forced 0 over the same window.
  - IDLE resumes at cycle t+2+RECOVER_CYCLES.
- Correctly predicted retire (cond=0): no flush and no stall; back-to-back retires are allowed every cycle.
- Counters wrap from 0xFFFF to 0.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → all outputs 0 immediately; `branch_ready`=0 for any retire.
- Not-taken: resolve idx 3 with cond=0; retire idx 3 the next cycle → `branch_ready`=1, `flush` never asserts, `branch_count`=1, entry 3 cleared. A second retire of idx 3 gives `branch_ready`=0.
- Mispredict: resolve idx 5, cond=1, target 0x0000_1040; retire idx 5 at cycle t → `flush`=1 and `redirect_pc`=0x0000_1040 at t+1 only; with RECOVER_CYCLES=2, `fetch_stall` high for t+1..t+3; `mispredict_count`=1.
- Bypass: resolve and retire idx 2 in the same cycle with cond=1, target 0x200 → `branch_ready`=1 that cycle; flush with 0x200 next cycle.
- Flush squash:
  - Preload idx 0, 1, 6.
  - Mispredict-retire idx 0.
  - Resolve idx 7 during RECOVER.
  - After IDLE, retires of idx 1, 6 and 7 → `branch_ready`=0.
- Wrap: drive 65536 cond=0 retires → `branch_count` returns to 0.
